alwr_demux_axis_fifo: RTL and testbench
=======================================

# alwr_demux_axis_fifo

Registered AL write-channel demultiplexer that steers each accepted write, by word address, into one of ADDR_TOTAL per-channel FIFOs. Each FIFO drives its own AXIS master lane. Writes to unmapped addresses are absorbed rather than stalled. The block sits between an AL register/stream write port and independent downstream AXIS consumers that may back-pressure separately.

## Interface
Parameters:
- DATA_BITS, 2: log2 of bytes per word; address LSBs dropped.
- DATA_WIDTH, 8 << DATA_BITS: word width.
- ADDR_TOTAL, 2: number of output channels, 1..16.
- ADDR_WIDTH, $clog2(ADDR_TOTAL) + DATA_BITS: byte-address width; may exceed the minimum.
- FIFO_DEPTH_BITS, 1: per-channel FIFO depth = 2^FIFO_DEPTH_BITS, 1..5.

Ports:
- clk, in, 1: sole clock.
- rst, in, 1: reset, asynchronous, active-high.
- s_al_waddr, in, [ADDR_WIDTH-1:DATA_BITS]: word address.
- s_al_wdata, in, DATA_WIDTH: write data.
- s_al_wvalid, in, 1: write valid.
- s_al_wready, out, 1: write accepted.
- mn_axis_data, out, ADDR_TOTAL*DATA_WIDTH: lane i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- mn_axis_valid, out, ADDR_TOTAL: per-lane valid.
- mn_axis_ready, in, ADDR_TOTAL: per-lane ready.
- drop_cnt, out, 16: count of writes to unmapped addresses.

## Operation
- Mapped write: s_al_waddr < ADDR_TOTAL. It is accepted when s_al_wvalid && s_al_wready, and pushed into FIFO[s_al_waddr].
- Unmapped write: s_al_waddr >= ADDR_TOTAL. s_al_wready = 1, the data is discarded, and drop_cnt updates (see Configuration).
- s_al_wready for a mapped address = !full[s_al_waddr]. This is combinational from the address and registered full flags only, with no dependence on mn_axis_ready.
- A full FIFO refuses a push even while it pops in the same cycle. There is no full-bypass.
- Per channel: a write pointer and a read pointer of FIFO_DEPTH_BITS bits each, which wrap modulo depth, plus a count of FIFO_DEPTH_BITS+1 bits.
  - full = (count == depth); empty = (count == 0).
  - Push only: count+1. Pop only: count-1. Push and pop together: count unchanged, both pointers advance.
- mn_axis_valid[i] = !empty[i]. Lane data = head entry of FIFO[i] and is stable while valid && !ready.
- A pop occurs when mn_axis_valid[i] && mn_axis_ready[i].
- Channels are independent. A stalled lane never blocks writes to other lanes.
- Order within a channel is strict FIFO. No ordering exists across channels.
- At most one push per cycle (one AL write port). Up to ADDR_TOTAL pops per cycle.

## Timing
- Latency: a write accepted on edge T makes mn_axis_valid high after edge T (first cycle T+1) if the FIFO was empty. There is no combinational path from s_al_* to mn_axis_*.
- Throughput: one write per clock to any non-full channel. One beat per clock per lane.
- Reset, asynchronous assert: all pointers and counts are 0, mn_axis_valid = 0, drop_cnt = 0.
  - s_al_wready is forced to 0 while rst = 1.
  - mn_axis_data is don't-care while valid = 0.
- Reset mid-operation: all FIFO contents are lost. A write presented during rst is not accepted. Operation resumes on the first edge after rst deasserts.
- Full boundary: with depth 2, write 2 words to a lane held at ready = 0. A third write to that lane sees s_al_wready = 0.
  - When ready rises, a pop occurs at the next edge. s_al_wready for that lane returns to 1 in the following cycle.
- Empty boundary: a pop of the last entry with no simultaneous push makes valid 0 after that edge.

## Configuration
- ALWR_DEMUX_AXIS_DROP_CNT_EN defined:
  - drop_cnt increments by 1 per accepted unmapped write.
  - It saturates at 16'hFFFF and clears only on rst.
- Not defined: drop_cnt is tied to 0 and no counter logic is generated. Unmapped writes are still accepted and discarded.

## Test plan
- Basic steer:
  - Stimulus: ADDR_TOTAL=4, all ready = 1; write 0xA0..0xA3 to word addresses 0..3 on consecutive cycles.
  - Required: each lane i shows 0xA0+i with valid for exactly 1 cycle, 1 cycle after its write; wready stays 1.
- Back-pressure/full:
  - Stimulus: FIFO_DEPTH_BITS=1, lane 1 ready = 0; write 0x11, 0x22, 0x33 to address 1.
  - Required: third write stalls (wready = 0). Raise ready and the lane emits 0x11, 0x22, then 0x33 after the retry is accepted, in order.
- Lane independence:
  - Stimulus: lane 0 full and stalled; write 0x55 to address 1.
  - Required: accepted immediately; lane 1 emits 0x55 while lane 0 holds its head data unchanged.
- Simultaneous push/pop:
  - Stimulus: lane 2 holds 1 entry with ready = 1; write address 2 in the same cycle.
  - Required: count stays 1, valid stays high, data sequence is preserved.
- Unmapped address:
  - Stimulus: ADDR_TOTAL=3; write address 3 five times.
  - Required: wready = 1 every cycle and no lane valid asserts. drop_cnt = 5 with the macro, 0 without. Saturation check: preload to 16'hFFFE, then 3 drops gives 16'hFFFF.
- Reset mid-stream:
  - Stimulus: assert rst asynchronously with 2 entries queued on lane 0.
  - Required: mn_axis_valid = 0 and wready = 0 immediately. After deassert, the lane is empty and the next write is delivered normally.

Source files
------------

// File: rtl/alwr_demux_axis_fifo.sv
// ---------------------------------------------------------------------------
// alwr_demux_axis_fifo
//
// Purpose:
//   Steers each accepted AL write into one of ADDR_TOTAL small FIFOs chosen by
//   the word address. Every FIFO feeds its own AXIS master lane, and each lane
//   can back-pressure on its own. Writes to unmapped word addresses
//   (address >= ADDR_TOTAL) are always accepted and thrown away.
//
// Ports:
//   clk            - sole clock
//   rst            - asynchronous, active-high reset
//   s_al_waddr     - word address (byte-address LSBs already dropped)
//   s_al_wdata     - write data
//   s_al_wvalid    - write valid
//   s_al_wready    - write accepted; 0 while rst or when the target FIFO is full
//   mn_axis_data   - lane i data at [i*DATA_WIDTH +: DATA_WIDTH] (FIFO head)
//   mn_axis_valid  - per-lane valid (FIFO not empty)
//   mn_axis_ready  - per-lane ready from the downstream consumers
//   drop_cnt       - number of writes to unmapped addresses (saturating)
//
// Configuration:
//   ALWR_DEMUX_AXIS_DROP_CNT_EN - when defined, drop_cnt counts accepted
//   unmapped writes and saturates at 16'hFFFF. When undefined, drop_cnt is
//   tied to zero and no counter is built.
// ---------------------------------------------------------------------------
module alwr_demux_axis_fifo #(
   parameter int DATA_BITS       = 2,
   parameter int DATA_WIDTH      = 8 << DATA_BITS,
   parameter int ADDR_TOTAL      = 2,
   parameter int ADDR_WIDTH      = $clog2(ADDR_TOTAL) + DATA_BITS,
   parameter int FIFO_DEPTH_BITS = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [ADDR_WIDTH-1:DATA_BITS]    s_al_waddr,
   input  logic [DATA_WIDTH-1:0]            s_al_wdata,
   input  logic                             s_al_wvalid,
   output logic                             s_al_wready,
   output logic [ADDR_TOTAL*DATA_WIDTH-1:0] mn_axis_data,
   output logic [ADDR_TOTAL-1:0]            mn_axis_valid,
   input  logic [ADDR_TOTAL-1:0]            mn_axis_ready,
   output logic [15:0]                      drop_cnt
);

   localparam int DEPTH = 1 << FIFO_DEPTH_BITS;

   // A count equal to the depth means full; the count is one bit wider than
   // the pointers so that this value is representable.
   localparam logic [FIFO_DEPTH_BITS:0] FULL_CNT = {1'b1, {FIFO_DEPTH_BITS{1'b0}}};

   logic [FIFO_DEPTH_BITS-1:0] wptr_q [ADDR_TOTAL];
   logic [FIFO_DEPTH_BITS-1:0] wptr_d [ADDR_TOTAL];
   logic [FIFO_DEPTH_BITS-1:0] rptr_q [ADDR_TOTAL];
   logic [FIFO_DEPTH_BITS-1:0] rptr_d [ADDR_TOTAL];
   logic [FIFO_DEPTH_BITS:0]   cnt_q  [ADDR_TOTAL];
   logic [FIFO_DEPTH_BITS:0]   cnt_d  [ADDR_TOTAL];
   logic [DATA_WIDTH-1:0]      mem_q  [ADDR_TOTAL][DEPTH];
   logic [DATA_WIDTH-1:0]      mem_d  [ADDR_TOTAL][DEPTH];

   logic [31:0]           waddr_ext;
   logic                  mapped;
   logic                  accept;
   logic [ADDR_TOTAL-1:0] hit;
   logic [ADDR_TOTAL-1:0] full;
   logic [ADDR_TOTAL-1:0] empty;
   logic [ADDR_TOTAL-1:0] push;
   logic [ADDR_TOTAL-1:0] pop;

   // Widen the word address so the mapped test works for any ADDR_WIDTH,
   // including addresses wider than the minimum needed for ADDR_TOTAL lanes.
   assign waddr_ext = 32'(s_al_waddr);
   assign mapped    = waddr_ext < 32'(ADDR_TOTAL);

   // One-hot lane select plus per-lane status derived only from the
   // registered counts, so wready never depends on downstream ready.
   always_comb begin
      hit   = '0;
      full  = '0;
      empty = '0;
      for (int i = 0; i < ADDR_TOTAL; i++) begin
         hit[i]   = mapped && (waddr_ext == 32'(i));
         full[i]  = (cnt_q[i] == FULL_CNT);
         empty[i] = (cnt_q[i] == '0);
      end
   end

   // Unmapped writes see no hit and are therefore always ready; a full target
   // lane refuses the write even if it is popping in this same cycle.
   assign s_al_wready = !rst && !(|(hit & full));
   assign accept      = s_al_wvalid && s_al_wready;

   // Push/pop strobes per lane, then next-state pointers, counts and storage.
   always_comb begin
      push  = '0;
      pop   = '0;
      mem_d = mem_q;
      for (int i = 0; i < ADDR_TOTAL; i++) begin
         push[i]   = accept && hit[i];
         pop[i]    = !empty[i] && mn_axis_ready[i];
         wptr_d[i] = wptr_q[i];
         rptr_d[i] = rptr_q[i];
         cnt_d[i]  = cnt_q[i];
         if (push[i]) begin
            wptr_d[i]             = wptr_q[i] + 1'b1;
            mem_d[i][wptr_q[i]]   = s_al_wdata;
         end
         if (pop[i]) begin
            rptr_d[i] = rptr_q[i] + 1'b1;
         end
         case ({push[i], pop[i]})
            2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
            2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
            default: cnt_d[i] = cnt_q[i];
         endcase
      end
   end

   // Pointer and occupancy registers; reset empties every lane at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ADDR_TOTAL; i++) begin
            wptr_q[i] <= '0;
            rptr_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < ADDR_TOTAL; i++) begin
            wptr_q[i] <= wptr_d[i];
            rptr_q[i] <= rptr_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
      end
   end

   // FIFO storage carries no reset: its contents only matter while the
   // matching count is non-zero.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Each lane presents its head entry; valid follows the registered count.
   always_comb begin
      mn_axis_data  = '0;
      mn_axis_valid = '0;
      for (int i = 0; i < ADDR_TOTAL; i++) begin
         mn_axis_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i][rptr_q[i]];
         mn_axis_valid[i]                         = !empty[i];
      end
   end

`ifdef ALWR_DEMUX_AXIS_DROP_CNT_EN
   logic [15:0] drop_cnt_q;
   logic [15:0] drop_cnt_d;

   // Count accepted unmapped writes, holding at all-ones instead of wrapping.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (accept && !mapped && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   // The drop counter clears only on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_alwr_demux_axis_fifo.sv
// ---------------------------------------------------------------------------
// tb_alwr_demux_axis_fifo
//
// Directed bench for alwr_demux_axis_fifo configured with three 32-bit lanes,
// depth-2 FIFOs and a 3-bit word address, so addresses 3..7 are unmapped.
// Expected drop_cnt values follow ALWR_DEMUX_AXIS_DROP_CNT_EN.
// ---------------------------------------------------------------------------
module tb_alwr_demux_axis_fifo;

   localparam int DB = 2;
   localparam int DW = 32;
   localparam int NL = 3;
   localparam int AW = 5;
   localparam int FB = 1;

   logic              clk;
   logic              rst;
   logic [AW-1:DB]    sAlWaddr;
   logic [DW-1:0]     sAlWdata;
   logic              sAlWvalid;
   logic              sAlWready;
   logic [NL*DW-1:0]  mnAxisData;
   logic [NL-1:0]     mnAxisValid;
   logic [NL-1:0]     mnAxisReady;
   logic [15:0]       dropCnt;

   int vecCount;
   int missCount;

   alwr_demux_axis_fifo #(
      .DATA_BITS       (DB),
      .DATA_WIDTH      (DW),
      .ADDR_TOTAL      (NL),
      .ADDR_WIDTH      (AW),
      .FIFO_DEPTH_BITS (FB)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .s_al_waddr    (sAlWaddr),
      .s_al_wdata    (sAlWdata),
      .s_al_wvalid   (sAlWvalid),
      .s_al_wready   (sAlWready),
      .mn_axis_data  (mnAxisData),
      .mn_axis_valid (mnAxisValid),
      .mn_axis_ready (mnAxisReady),
      .drop_cnt      (dropCnt)
   );

   // Free-running clock, rising edge active.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive the write port and the per-lane ready vector.
   task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data,
                                input logic valid, input logic [2:0] ready);
      sAlWaddr    = addr;
      sAlWdata    = data;
      sAlWvalid   = valid;
      mnAxisReady = ready;
   endtask

   // Single comparison point: counts the vector and reports any difference.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecCount++;
      if (obs !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next active edge.
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] laneData(input int i);
      return mnAxisData[i*DW +: DW];
   endfunction

   logic [15:0] expDrop;

   initial begin
      vecCount  = 0;
      missCount = 0;
      rst       = 1'b1;
      applyStimulus(3'd0, 32'h0, 1'b0, 3'b000);

      // Reset state.
      @(negedge clk);
      checkOutput("rst_valid", 64'(mnAxisValid), 64'h0);
      checkOutput("rst_wready", 64'(sAlWready), 64'h0);
      checkOutput("rst_drop", 64'(dropCnt), 64'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic steer: one word per lane, each visible for exactly one cycle.
      for (int k = 0; k < 4; k++) begin
         if (k < 3) applyStimulus(3'(k), 32'hA0 + 32'(k), 1'b1, 3'b111);
         else       applyStimulus(3'd0, 32'h0, 1'b0, 3'b111);
         @(negedge clk);
         if (k < 3) checkOutput("steer_wready", 64'(sAlWready), 64'h1);
         checkOutput("steer_valid", 64'(mnAxisValid), (k > 0) ? 64'(1 << (k - 1)) : 64'h0);
         if (k > 0) checkOutput("steer_data", 64'(laneData(k - 1)), 64'hA0 + 64'(k - 1));
         stepCycle();
      end
      checkOutput("steer_idle", 64'(mnAxisValid), 64'h0);

      // Back-pressure on lane 1 until full, then release.
      applyStimulus(3'd1, 32'h11, 1'b1, 3'b101);
      @(negedge clk);
      checkOutput("bp_wr1_ready", 64'(sAlWready), 64'h1);
      stepCycle();
      applyStimulus(3'd1, 32'h22, 1'b1, 3'b101);
      @(negedge clk);
      checkOutput("bp_wr2_ready", 64'(sAlWready), 64'h1);
      checkOutput("bp_head_11a", 64'(laneData(1)), 64'h11);
      stepCycle();
      applyStimulus(3'd1, 32'h33, 1'b1, 3'b101);
      @(negedge clk);
      checkOutput("bp_full_stall", 64'(sAlWready), 64'h0);
      checkOutput("bp_head_11b", 64'(laneData(1)), 64'h11);
      stepCycle();
      applyStimulus(3'd1, 32'h33, 1'b1, 3'b111);
      @(negedge clk);
      checkOutput("bp_ready_rise_stall", 64'(sAlWready), 64'h0);
      checkOutput("bp_emit_11", 64'(laneData(1)), 64'h11);
      stepCycle();
      @(negedge clk);
      checkOutput("bp_retry_ready", 64'(sAlWready), 64'h1);
      checkOutput("bp_emit_22", 64'(laneData(1)), 64'h22);
      stepCycle();
      applyStimulus(3'd1, 32'h0, 1'b0, 3'b111);
      @(negedge clk);
      checkOutput("bp_valid_33", 64'(mnAxisValid), 64'h2);
      checkOutput("bp_emit_33", 64'(laneData(1)), 64'h33);
      stepCycle();
      checkOutput("bp_empty", 64'(mnAxisValid), 64'h0);

      // Lane independence: fill and stall lane 0, then write lane 1.
      applyStimulus(3'd0, 32'h40, 1'b1, 3'b010);
      stepCycle();
      applyStimulus(3'd0, 32'h41, 1'b1, 3'b010);
      stepCycle();
      applyStimulus(3'd1, 32'h55, 1'b1, 3'b010);
      @(negedge clk);
      checkOutput("ind_wready", 64'(sAlWready), 64'h1);
      checkOutput("ind_l0_head_a", 64'(laneData(0)), 64'h40);
      stepCycle();
      applyStimulus(3'd0, 32'h0, 1'b0, 3'b010);
      @(negedge clk);
      checkOutput("ind_l0_full", 64'(sAlWready), 64'h0);
      checkOutput("ind_valid", 64'(mnAxisValid), 64'h3);
      checkOutput("ind_l1_data", 64'(laneData(1)), 64'h55);
      checkOutput("ind_l0_head_b", 64'(laneData(0)), 64'h40);
      stepCycle();
      checkOutput("ind_after", 64'(mnAxisValid), 64'h1);
      checkOutput("ind_l0_head_c", 64'(laneData(0)), 64'h40);

      // Simultaneous push and pop on lane 2.
      applyStimulus(3'd2, 32'h61, 1'b1, 3'b010);
      stepCycle();
      applyStimulus(3'd2, 32'h62, 1'b1, 3'b110);
      @(negedge clk);
      checkOutput("pp_wready", 64'(sAlWready), 64'h1);
      checkOutput("pp_data_61", 64'(laneData(2)), 64'h61);
      stepCycle();
      applyStimulus(3'd2, 32'h63, 1'b1, 3'b110);
      @(negedge clk);
      checkOutput("pp_valid_a", 64'(mnAxisValid), 64'h5);
      checkOutput("pp_data_62", 64'(laneData(2)), 64'h62);
      stepCycle();
      applyStimulus(3'd0, 32'h0, 1'b0, 3'b110);
      @(negedge clk);
      checkOutput("pp_valid_b", 64'(mnAxisValid), 64'h5);
      checkOutput("pp_data_63", 64'(laneData(2)), 64'h63);
      stepCycle();
      checkOutput("pp_drained", 64'(mnAxisValid), 64'h1);

      // Unmapped address: always accepted, never reaches a lane.
      for (int k = 0; k < 5; k++) begin
         applyStimulus(3'd3, 32'hD0 + 32'(k), 1'b1, 3'b010);
         @(negedge clk);
         checkOutput("unm_wready", 64'(sAlWready), 64'h1);
         checkOutput("unm_no_valid", 64'(mnAxisValid[2:1]), 64'h0);
         stepCycle();
      end
      applyStimulus(3'd0, 32'h0, 1'b0, 3'b010);
`ifdef ALWR_DEMUX_AXIS_DROP_CNT_EN
      expDrop = 16'd5;
`else
      expDrop = 16'd0;
`endif
      @(negedge clk);
      checkOutput("unm_drop5", 64'(dropCnt), 64'(expDrop));
      checkOutput("unm_lanes", 64'(mnAxisValid), 64'h1);
`ifdef ALWR_DEMUX_AXIS_DROP_CNT_EN
      // Walk the counter up to 16'hFFFE, then three more drops must saturate.
      applyStimulus(3'd7, 32'hEE, 1'b1, 3'b010);
      repeat (65529) @(posedge clk);
      #1;
      sAlWvalid = 1'b0;
      @(negedge clk);
      checkOutput("unm_drop_fffe", 64'(dropCnt), 64'hFFFE);
      sAlWvalid = 1'b1;
      repeat (3) stepCycle();
      sAlWvalid = 1'b0;
      @(negedge clk);
      checkOutput("unm_drop_sat", 64'(dropCnt), 64'hFFFF);
`endif

      // Reset mid-stream with two entries held on lane 0.
      stepCycle();
      applyStimulus(3'd1, 32'h99, 1'b1, 3'b010);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("mrst_valid", 64'(mnAxisValid), 64'h0);
      checkOutput("mrst_wready", 64'(sAlWready), 64'h0);
      checkOutput("mrst_drop", 64'(dropCnt), 64'h0);
      stepCycle();
      rst = 1'b0;
      applyStimulus(3'd0, 32'h0, 1'b0, 3'b111);
      @(negedge clk);
      checkOutput("mrst_empty", 64'(mnAxisValid), 64'h0);
      stepCycle();
      applyStimulus(3'd0, 32'h88, 1'b1, 3'b111);
      @(negedge clk);
      checkOutput("mrst_wr_ready", 64'(sAlWready), 64'h1);
      stepCycle();
      applyStimulus(3'd0, 32'h0, 1'b0, 3'b111);
      @(negedge clk);
      checkOutput("mrst_valid_88", 64'(mnAxisValid), 64'h1);
      checkOutput("mrst_data_88", 64'(laneData(0)), 64'h88);
      stepCycle();
      checkOutput("mrst_final", 64'(mnAxisValid), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
